pong_engine: RTL



---
 rtl/pong_pkg.sv | 19 +
 rtl/pong_paddle.sv | 63 ++++++
 rtl/pong_engine.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pong_pkg.sv
// Shared types for the Pong game-state engine.
//   state_t : match FSM encoding, visible on the game_state output
//   dir_t   : ball direction along one axis, stored as a sign bit
package pong_pkg;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StServe = 3'd1,
    StPlay  = 3'd2,
    StPoint = 3'd3,
    StOver  = 3'd4
  } state_t;

  typedef enum logic {
    DirPos = 1'b0,
    DirNeg = 1'b1
  } dir_t;

endpackage

// File: rtl/pong_paddle.sv
// One paddle: synchronises its two raw active-low keys and steps the paddle
// top coordinate once per frame tick while enabled, clamped to the field.
//   clk_i, rst_ni    : clock, asynchronous active-low reset
//   tick_i           : frame tick
//   enable_i         : paddle may move on this tick
//   clear_i          : return paddle to the centre (match restart)
//   key_up_ni/dn_ni  : raw active-low keys
//   y_o              : paddle top coordinate
module pong_paddle #(
  parameter int unsigned V_RES       = 480,
  parameter int unsigned PADDLE_H    = 64,
  parameter int unsigned PADDLE_STEP = 4,
  parameter int unsigned COORD_W     = 10
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               tick_i,
  input  logic               enable_i,
  input  logic               clear_i,
  input  logic               key_up_ni,
  input  logic               key_dn_ni,
  output logic [COORD_W-1:0] y_o
);

  localparam logic [COORD_W-1:0] YMax = COORD_W'(V_RES - PADDLE_H);
  localparam logic [COORD_W-1:0] YRst = COORD_W'((V_RES - PADDLE_H) / 2);
  localparam logic [COORD_W-1:0] Step = COORD_W'(PADDLE_STEP);

  logic [1:0]         up_sync_q, dn_sync_q;
  logic [COORD_W-1:0] y_q, y_d;
  logic               up, dn;

  assign up = ~up_sync_q[1];
  assign dn = ~dn_sync_q[1];

  always_comb begin
    y_d = y_q;
    if (clear_i) begin
      y_d = YRst;
    end else if (tick_i && enable_i) begin
      if (up && !dn) begin
        y_d = (y_q < Step) ? '0 : y_q - Step;
      end else if (dn && !up) begin
        y_d = (y_q > YMax - Step) ? YMax : y_q + Step;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      up_sync_q <= 2'b11;  // released keys read high
      dn_sync_q <= 2'b11;
      y_q       <= YRst;
    end else begin
      up_sync_q <= {up_sync_q[0], key_up_ni};
      dn_sync_q <= {dn_sync_q[0], key_dn_ni};
      y_q       <= y_d;
    end
  end

  assign y_o = y_q;

endmodule

// File: rtl/pong_engine.sv
// Pong game-state engine: ball position/velocity, both paddles, scores and
// the match FSM. All motion advances once per frame_tick; outputs registered.
//   clk_clk, reset_reset_n        : clock, asynchronous active-low reset
//   frame_tick                    : one-cycle pulse per frame
//   buttons_export[3:0]           : raw active-low keys (L up, L dn, R up, R dn)
//   start                         : level, sampled on frame_tick
//   bola_x/y_out_export           : ball top-left corner
//   barra_e/d_y_out_export        : left/right paddle top
//   score_e/score_d               : left/right score
//   game_state                    : encoded FSM state
//   point_pulse                   : one-cycle pulse with each score update
module pong_engine
  import pong_pkg::*;
#(
  parameter int unsigned H_RES        = 640,
  parameter int unsigned V_RES        = 480,
  parameter int unsigned COORD_W      = 10,
  parameter int unsigned BALL_SIZE    = 8,
  parameter int unsigned PADDLE_H     = 64,
  parameter int unsigned PADDLE_W     = 8,
  parameter int unsigned PADDLE_X     = 16,
  parameter int unsigned BALL_STEP    = 2,
  parameter int unsigned PADDLE_STEP  = 4,
  parameter int unsigned SERVE_FRAMES = 60,
  parameter int unsigned POINT_FRAMES = 90,
  parameter int unsigned SCORE_W      = 4,
  parameter int unsigned WIN_SCORE    = 9
) (
  input  logic               clk_clk,
  input  logic               reset_reset_n,
  input  logic               frame_tick,
  input  logic [3:0]         buttons_export,
  input  logic               start,
  output logic [COORD_W-1:0] bola_x_out_export,
  output logic [COORD_W-1:0] bola_y_out_export,
  output logic [COORD_W-1:0] barra_e_y_out_export,
  output logic [COORD_W-1:0] barra_d_y_out_export,
  output logic [SCORE_W-1:0] score_e,
  output logic [SCORE_W-1:0] score_d,
  output logic [2:0]         game_state,
  output logic               point_pulse
);

  localparam int unsigned SW       = COORD_W + 2;
  localparam int unsigned FrameMax = (SERVE_FRAMES > POINT_FRAMES) ? SERVE_FRAMES : POINT_FRAMES;
  localparam int unsigned CntW     = (FrameMax > 1) ? $clog2(FrameMax) : 1;

  localparam logic [COORD_W-1:0] BallX0 = COORD_W'((H_RES - BALL_SIZE) / 2);
  localparam logic [COORD_W-1:0] BallY0 = COORD_W'((V_RES - BALL_SIZE) / 2);
  localparam logic [COORD_W-1:0] YBMax  = COORD_W'(V_RES - BALL_SIZE);
  localparam logic [COORD_W-1:0] XBMax  = COORD_W'(H_RES - BALL_SIZE);
  localparam logic [COORD_W-1:0] LFace  = COORD_W'(PADDLE_X + PADDLE_W);
  localparam logic [COORD_W-1:0] RFace  = COORD_W'(H_RES - PADDLE_X - PADDLE_W - BALL_SIZE);

  // Signed copies for the COORD_W+2 ball arithmetic.
  localparam logic signed [SW-1:0] SZero  = '0;
  localparam logic signed [SW-1:0] SStep  = SW'(BALL_STEP);
  localparam logic signed [SW-1:0] SBall  = SW'(BALL_SIZE);
  localparam logic signed [SW-1:0] SPadH  = SW'(PADDLE_H);
  localparam logic signed [SW-1:0] SYBMax = SW'(V_RES - BALL_SIZE);
  localparam logic signed [SW-1:0] SXBMax = SW'(H_RES - BALL_SIZE);
  localparam logic signed [SW-1:0] SLFace = SW'(PADDLE_X + PADDLE_W);
  localparam logic signed [SW-1:0] SRFace = SW'(H_RES - PADDLE_X - PADDLE_W - BALL_SIZE);

  localparam logic [CntW-1:0]    ServeLast = CntW'(SERVE_FRAMES - 1);
  localparam logic [CntW-1:0]    PointLast = CntW'(POINT_FRAMES - 1);
  localparam logic [SCORE_W-1:0] WinScore  = SCORE_W'(WIN_SCORE);

  state_t             state_q, state_d;
  logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
  dir_t               dx_q, dx_d, dy_q, dy_d;
  logic [SCORE_W-1:0] score_l_q, score_l_d, score_r_q, score_r_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic               pulse_q, pulse_d;
  logic               pad_clear, pad_en;
  logic [COORD_W-1:0] pad_l, pad_r;

  logic signed [SW-1:0] sx, sy, nx, ny, spl, spr;
  logic                 ovl_l, ovl_r;

  assign pad_en = (state_q == StServe) || (state_q == StPlay);

  pong_paddle #(
    .V_RES      (V_RES),
    .PADDLE_H   (PADDLE_H),
    .PADDLE_STEP(PADDLE_STEP),
    .COORD_W    (COORD_W)
  ) u_paddle_l (
    .clk_i    (clk_clk),
    .rst_ni   (reset_reset_n),
    .tick_i   (frame_tick),
    .enable_i (pad_en),
    .clear_i  (pad_clear),
    .key_up_ni(buttons_export[0]),
    .key_dn_ni(buttons_export[1]),
    .y_o      (pad_l)
  );

  pong_paddle #(
    .V_RES      (V_RES),
    .PADDLE_H   (PADDLE_H),
    .PADDLE_STEP(PADDLE_STEP),
    .COORD_W    (COORD_W)
  ) u_paddle_r (
    .clk_i    (clk_clk),
    .rst_ni   (reset_reset_n),
    .tick_i   (frame_tick),
    .enable_i (pad_en),
    .clear_i  (pad_clear),
    .key_up_ni(buttons_export[2]),
    .key_dn_ni(buttons_export[3]),
    .y_o      (pad_r)
  );

  assign sx  = $signed({2'b00, x_q});
  assign sy  = $signed({2'b00, y_q});
  assign spl = $signed({2'b00, pad_l});
  assign spr = $signed({2'b00, pad_r});
  assign nx  = (dx_q == DirPos) ? sx + SStep : sx - SStep;
  assign ny  = (dy_q == DirPos) ? sy + SStep : sy - SStep;

  // Overlap uses paddle positions from before this tick's paddle update.
  assign ovl_l = (sy + SBall > spl) && (sy < spl + SPadH);
  assign ovl_r = (sy + SBall > spr) && (sy < spr + SPadH);

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    dx_d      = dx_q;
    dy_d      = dy_q;
    score_l_d = score_l_q;
    score_r_d = score_r_q;
    cnt_d     = cnt_q;
    pulse_d   = 1'b0;
    pad_clear = 1'b0;
    if (frame_tick) begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_d = StServe;
            cnt_d   = '0;
            x_d     = BallX0;
            y_d     = BallY0;
          end
        end
        StServe: begin
          x_d = BallX0;
          y_d = BallY0;
          if (cnt_q == ServeLast) begin
            state_d = StPlay;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        StPlay: begin
          // Vertical wall reflection, independent of the horizontal outcome.
          if (ny < SZero) begin
            y_d  = '0;
            dy_d = DirPos;
          end else if (ny > SYBMax) begin
            y_d  = YBMax;
            dy_d = DirNeg;
          end else begin
            y_d = ny[COORD_W-1:0];
          end

          if (dx_q == DirNeg && sx >= SLFace && nx < SLFace && ovl_l) begin
            x_d  = LFace;
            dx_d = DirPos;
          end else if (dx_q == DirPos && sx <= SRFace && nx > SRFace && ovl_r) begin
            x_d  = RFace;
            dx_d = DirNeg;
          end else if (nx <= SZero) begin
            // Right scores; next serve heads toward the left player.
            x_d       = '0;
            dx_d      = DirNeg;
            score_r_d = score_r_q + 1'b1;
            pulse_d   = 1'b1;
            cnt_d     = '0;
            state_d   = (score_r_d == WinScore) ? StOver : StPoint;
          end else if (nx >= SXBMax) begin
            x_d       = XBMax;
            dx_d      = DirPos;
            score_l_d = score_l_q + 1'b1;
            pulse_d   = 1'b1;
            cnt_d     = '0;
            state_d   = (score_l_d == WinScore) ? StOver : StPoint;
          end else begin
            x_d = nx[COORD_W-1:0];
          end
        end
        StPoint: begin
          if (cnt_q == PointLast) begin
            state_d = StServe;
            cnt_d   = '0;
            x_d     = BallX0;
            y_d     = BallY0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        StOver: begin
          if (start) begin
            state_d   = StIdle;
            x_d       = BallX0;
            y_d       = BallY0;
            dx_d      = DirPos;
            dy_d      = DirPos;
            score_l_d = '0;
            score_r_d = '0;
            pad_clear = 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q   <= StIdle;
      x_q       <= BallX0;
      y_q       <= BallY0;
      dx_q      <= DirPos;
      dy_q      <= DirPos;
      score_l_q <= '0;
      score_r_q <= '0;
      cnt_q     <= '0;
      pulse_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      dx_q      <= dx_d;
      dy_q      <= dy_d;
      score_l_q <= score_l_d;
      score_r_q <= score_r_d;
      cnt_q     <= cnt_d;
      pulse_q   <= pulse_d;
    end
  end

  assign bola_x_out_export    = x_q;
  assign bola_y_out_export    = y_q;
  assign barra_e_y_out_export = pad_l;
  assign barra_d_y_out_export = pad_r;
  assign score_e              = score_l_q;
  assign score_d              = score_r_q;
  assign game_state           = state_q;
  assign point_pulse          = pulse_q;

endmodule
